// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: runtime scale controller for the clock divider; new scales apply only at period boundaries.
// Optional macro CLKDIV_CTRL_PERIOD_CNT_EN adds the period_cnt output.
module clkdiv_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CONST     = 200000,
    parameter int CNT_W     = 32,
    parameter int RST_SCALE = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_scale,
    output logic             req_ready,
    output logic             clk_out,
    output logic [WIDTH-1:0] active_scale,
    output logic             update_done,
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             busy
);
    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    localparam logic [CNT_W-1:0] HALF_K   = CNT_W'(CONST / 2);
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(RST_SCALE * CONST / 2);

    state_t           state;
    logic [CNT_W-1:0] cnt, half;
    logic [WIDTH-1:0] pend_scale;
    logic             div_q, run_q, bypass_q, en_q;
    logic             tick, byp, bnd, apply, halt, take;

    // run_q tracks whether the divider is actually ticking, so PEND knows if it must wait for a boundary
    assign tick      = cnt == half - CNT_W'(1);
    assign byp       = active_scale == '0;
    assign bnd       = run_q & ~byp & div_q & tick;
    assign apply     = (state == PEND) & (~run_q | byp | bnd);
    assign halt      = ~enable & (byp | bnd);
    assign take      = (state != PEND) & req_valid;
    assign req_ready = state != PEND;
    assign busy      = state == PEND;
    assign clk_out   = bypass_q ? (clk_in & en_q) : div_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= STOP;
            cnt          <= '0;
            half         <= RST_HALF;
            div_q        <= 1'b0;
            run_q        <= 1'b0;
            active_scale <= WIDTH'(RST_SCALE);
            pend_scale   <= '0;
            update_done  <= 1'b0;
        end else begin
            update_done <= apply;
            if (apply) begin
                active_scale <= pend_scale;
                half         <= CNT_W'(pend_scale) * HALF_K;
                cnt          <= '0;
                div_q        <= 1'b0;
                run_q        <= enable;
                state        <= enable ? RUN : STOP;
            end else begin
                cnt   <= (run_q & ~byp & ~tick) ? cnt + CNT_W'(1) : '0;
                div_q <= run_q & ~byp & (div_q ^ tick);
                run_q <= (state == STOP) ? enable & ~req_valid : run_q & ~((state == RUN) & halt);
                state <= take ? PEND : (state == STOP & enable) ? RUN : (state == RUN & halt) ? STOP : state;
                if (take) pend_scale <= req_scale;
            end
        end
    end

    // output mux selects change only while clk_in is low
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            bypass_q <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            bypass_q <= byp;
            en_q     <= enable;
        end
    end

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) period_cnt <= '0;
        else if (apply) period_cnt <= '0;
        else if ((state == RUN) & bnd) period_cnt <= period_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed scoreboard bench for clkdiv_ctrl with CONST=2 (half-period = scale cycles).
module tb_clkdiv_ctrl;
    logic       clk_in = 1'b0;
    logic       rst, enable, req_valid;
    logic [7:0] req_scale;
    logic       req_ready, clk_out, update_done, busy;
    logic [7:0] active_scale;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif
    logic [7:0] q[$];
    int n_cmp = 0;
    int n_bad = 0;

    clkdiv_ctrl #(.WIDTH(8), .CONST(2), .CNT_W(32), .RST_SCALE(1)) dut (
        .clk_in(clk_in), .rst(rst), .enable(enable), .req_valid(req_valid), .req_scale(req_scale),
        .req_ready(req_ready), .clk_out(clk_out), .active_scale(active_scale), .update_done(update_done),
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        .period_cnt(period_cnt),
`endif
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(negedge clk_in);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = 'x;
        if (q.size() > 0) e = q.pop_front();
        check(tag, 32'(active_scale), 32'(e));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (update_done !== 1'b1 && k < 100) begin
            nx();
            k++;
        end
        check({tag, "_done"}, 32'(update_done), 32'd1);
        pop_check({tag, "_scale"});
    endtask

    // expects to be called on the first sample of a phase; ends on the first sample of the next one
    task automatic phase(input string tag, input logic lvl, input int len);
        int n = 0;
        check({tag, "_lvl"}, 32'(clk_out), 32'(lvl));
        while (clk_out === lvl && n < 100) begin
            nx();
            n++;
        end
        check({tag, "_len"}, 32'(n), 32'(len));
    endtask

    task automatic send(input logic [7:0] s);
        int k = 0;
        req_valid = 1'b1;
        req_scale = s;
        while (!req_ready && k < 200) begin
            nx();
            k++;
        end
        nx();
        req_valid = 1'b0;
        check("send_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1; enable = 1'b0; req_valid = 1'b0; req_scale = '0;
        nx(); nx();
        check("rst_scale", 32'(active_scale), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(update_done), 32'd0);
        check("rst_clk", 32'(clk_out), 32'd0);
        // scale 1: toggles every cycle
        rst = 1'b0; enable = 1'b1;
        nx(); nx();
        phase("s1_a", 1'b1, 1);
        phase("s1_b", 1'b0, 1);
        phase("s1_c", 1'b1, 1);
        // 1 -> 2 -> 4
        q.push_back(8'd2);
        send(8'd2);
        wait_done("s2a");
        nx();
        check("s2_pulse", 32'(update_done), 32'd0);
        check("s2_ready", 32'(req_ready), 32'd1);
        q.push_back(8'd4);
        send(8'd4);
        check("s2_notready", 32'(req_ready), 32'd0);
        wait_done("s2b");
        phase("s2_lo", 1'b0, 4);
        phase("s2_hi", 1'b1, 4);
        // bypass, then back to divided scale 3
        q.push_back(8'd0);
        send(8'd0);
        wait_done("s3a");
        repeat (2) begin
            @(posedge clk_in); #1;
            check("s3_byp_hi", 32'(clk_out), 32'd1);
            @(negedge clk_in); #1;
            check("s3_byp_lo", 32'(clk_out), 32'd0);
        end
        q.push_back(8'd3);
        send(8'd3);
        wait_done("s3b");
        phase("s3_lo", 1'b0, 3);
        phase("s3_hi", 1'b1, 3);
        // scale 4, stop while high, then restart
        q.push_back(8'd4);
        send(8'd4);
        wait_done("s4");
        phase("s4_lo", 1'b0, 4);
        enable = 1'b0;
        phase("s4_hi_stop", 1'b1, 4);
        k = 0;
        repeat (10) begin
            k += int'(clk_out);
            nx();
        end
        check("s4_stopped", 32'(k), 32'd0);
        check("s4_stop_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        k = 0;
        while (clk_out !== 1'b1 && k < 50) begin
            nx();
            k++;
        end
        check("s4_restart", 32'(k), 32'd5);
        // request in a boundary cycle waits one more old period
        repeat (3) nx();
        check("s5_last_hi", 32'(clk_out), 32'd1);
        req_valid = 1'b1; req_scale = 8'd2;
        q.push_back(8'd2);
        nx();
        req_scale = 8'd5;
        check("s5_busy", 32'(busy), 32'd1);
        check("s5_ready", 32'(req_ready), 32'd0);
        phase("s5_old_lo", 1'b0, 4);
        phase("s5_old_hi", 1'b1, 4);
        check("s5_done", 32'(update_done), 32'd1);
        pop_check("s5_scale");
        check("s5_ready_again", 32'(req_ready), 32'd1);
        q.push_back(8'd5);
        nx();
        req_valid = 1'b0;
        check("s5_busy2", 32'(busy), 32'd1);
        wait_done("s5b");
        // reset while pending discards the request
        send(8'd7);
        rst = 1'b1;
        #1;
        check("s6_scale", 32'(active_scale), 32'd1);
        check("s6_clk", 32'(clk_out), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_ready", 32'(req_ready), 32'd1);
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        check("s6_pcnt0", 32'(period_cnt), 32'd0);
`endif
        nx();
        rst = 1'b0;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
        for (int i = 1; i <= 3; i++) begin
            k = 0;
            while (clk_out !== 1'b1 && k < 50) begin nx(); k++; end
            while (clk_out !== 1'b0 && k < 50) begin nx(); k++; end
            check("s6_pcnt", 32'(period_cnt), 32'(i));
        end
`else
        nx(); nx();
        phase("s6_hi", 1'b1, 1);
        phase("s6_lo", 1'b0, 1);
`endif
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
